// File: rtl/encoder_speed.sv
// ---------------------------------------------------------------------------
// encoder_speed
//   Samples an upstream position counter once per SAMPLE_PERIOD clocks and
//   reports the signed position change (counts per sample period). It corrects
//   the change for counter wrap and saturates it to 16 bits. Each result is
//   held in a valid/ready output register with a sticky overrun flag.
//
//   Optional build macro: ENCODER_SPEED_FILTER_EN
//     When defined, speed is the 4-tap moving average of the corrected deltas.
//     This adds one extra cycle of latency.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   count        in  16   unsigned position count, synchronous to clk
//   speed        out 16   signed counts per sample period
//   speed_valid  out  1   speed holds an unconsumed result
//   speed_ready  in   1   consumer accepts speed when high with speed_valid
//   overrun      out  1   sticky: a result was overwritten before acceptance
// ---------------------------------------------------------------------------
module encoder_speed #(
  parameter int ENCODER_MAX   = 64000,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        count,
  output logic signed [15:0] speed,
  output logic               speed_valid,
  input  logic               speed_ready,
  output logic               overrun
);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [23:0]        TIMER_LAST = 24'(SAMPLE_PERIOD - 1);
  localparam logic signed [17:0] HALF_MAX   = 18'(ENCODER_MAX / 2);
  localparam logic signed [17:0] FULL_MAX   = 18'(ENCODER_MAX);

  logic [23:0]        r_timer;
  logic               w_tick;
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_take;
  logic [15:0]        r_prev;
  logic signed [17:0] w_diff;
  logic signed [17:0] w_corr;
  logic signed [15:0] w_sat;
  logic               w_res_valid;
  logic signed [15:0] w_res_value;
  logic signed [15:0] r_speed;
  logic               r_speed_valid;
  logic               r_overrun;

  assign w_tick = (r_timer == TIMER_LAST);

  // Sample timer: counts 0..SAMPLE_PERIOD-1 and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 24'd0;
    end else if (w_tick) begin
      r_timer <= 24'd0;
    end else begin
      r_timer <= r_timer + 24'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state. The PRIME tick only seeds prev. Ticks in RUN produce a delta.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      ST_PRIME: begin
        if (w_tick) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_PRIME;
        end
      end
      ST_RUN: begin
        w_take = w_tick;
      end
      default: begin
        w_state_nxt = ST_PRIME;
      end
    endcase
  end

  // Previous-sample register, reloaded on every tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 16'd0;
    end else if (w_tick) begin
      r_prev <= count;
    end else begin
      r_prev <= r_prev;
    end
  end

  // The raw difference uses two guard bits. Even for counts outside
  // 0..ENCODER_MAX-1, the wrap-corrected value cannot overflow.
  assign w_diff = $signed({2'b00, count}) - $signed({2'b00, r_prev});

  // Wrap correction. A jump of more than half the modulus is taken to be a
  // pass through the counter's wrap point.
  always_comb begin
    w_corr = w_diff;
    if (w_diff > HALF_MAX) begin
      w_corr = w_diff - FULL_MAX;
    end else if (w_diff < -HALF_MAX) begin
      w_corr = w_diff + FULL_MAX;
    end else begin
      w_corr = w_diff;
    end
  end

  // Saturate to the 16-bit signed output range.
  always_comb begin
    w_sat = w_corr[15:0];
    if (w_corr > 18'sd32767) begin
      w_sat = 16'sh7FFF;
    end else if (w_corr < -18'sd32768) begin
      w_sat = 16'sh8000;
    end else begin
      w_sat = w_corr[15:0];
    end
  end

`ifdef ENCODER_SPEED_FILTER_EN
  logic signed [15:0] r_hist0;
  logic signed [15:0] r_hist1;
  logic signed [15:0] r_hist2;
  logic signed [15:0] r_hist3;
  logic               r_hist_new;
  logic signed [17:0] w_sum;

  // Delta history shift register. r_hist_new marks the cycle after a shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist0    <= 16'sd0;
      r_hist1    <= 16'sd0;
      r_hist2    <= 16'sd0;
      r_hist3    <= 16'sd0;
      r_hist_new <= 1'b0;
    end else begin
      r_hist_new <= w_take;
      if (w_take) begin
        r_hist0 <= w_sat;
        r_hist1 <= r_hist0;
        r_hist2 <= r_hist1;
        r_hist3 <= r_hist2;
      end
    end
  end

  assign w_sum = 18'(r_hist0) + 18'(r_hist1) + 18'(r_hist2) + 18'(r_hist3);
  assign w_res_valid = r_hist_new;
  // Taking bits [17:2] of the sum is an arithmetic shift right by 2.
  // The average always fits in 16 bits.
  assign w_res_value = w_sum[17:2];
`else
  assign w_res_valid = w_take;
  assign w_res_value = w_sat;
`endif

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed       <= 16'sd0;
      r_speed_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (w_res_valid) begin
      r_speed       <= w_res_value;
      r_speed_valid <= 1'b1;
      if (r_speed_valid && !speed_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_speed_valid && speed_ready) begin
      r_speed_valid <= 1'b0;
    end
  end

  assign speed       = r_speed;
  assign speed_valid = r_speed_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_encoder_speed.sv
// ---------------------------------------------------------------------------
// tb_encoder_speed
//   Directed self-checking bench for encoder_speed with SAMPLE_PERIOD=8.
//   Inputs change on falling edges, and outputs are sampled on falling edges.
//   After reset is released, sample ticks occur on rising edges 8, 16, 24 ...
//   Tick 8 is the PRIME tick.
// ---------------------------------------------------------------------------
module tb_encoder_speed;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        count;
  logic signed [15:0] speed;
  logic               speed_valid;
  logic               speed_ready;
  logic               overrun;

  int n_checks = 0;
  int n_errors = 0;

  encoder_speed #(
    .ENCODER_MAX  (64000),
    .SAMPLE_PERIOD(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .speed      (speed),
    .speed_valid(speed_valid),
    .speed_ready(speed_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    count       = 16'd0;
    speed_ready = 1'b1;
`ifdef ENCODER_SPEED_FILTER_EN
    step(3);
    chk("f_rst_speed", speed, 16'd0);
    chk("f_rst_valid", {15'd0, speed_valid}, 16'd0);
    rst = 1'b0;
    step(8);
    chk("f_prime", {15'd0, speed_valid}, 16'd0);
    count = 16'd40;
    step(8);
    chk("f_lat2_not_yet", {15'd0, speed_valid}, 16'd0);
    step(1);
    chk("f_avg1_valid", {15'd0, speed_valid}, 16'd1);
    chk("f_avg1", speed, 16'd10);
    count = 16'd80;
    step(7);
    chk("f_consumed", {15'd0, speed_valid}, 16'd0);
    step(1);
    chk("f_avg2", speed, 16'd20);
    count = 16'd120;
    step(8);
    chk("f_avg3", speed, 16'd30);
    count = 16'd160;
    step(8);
    chk("f_avg4", speed, 16'd40);
    chk("f_avg4_valid", {15'd0, speed_valid}, 16'd1);
`else
    // Reset values, then the PRIME tick produces no result.
    count = 16'd100;
    step(3);
    chk("rst_speed", speed, 16'd0);
    chk("rst_valid", {15'd0, speed_valid}, 16'd0);
    chk("rst_overrun", {15'd0, overrun}, 16'd0);
    rst = 1'b0;
    step(8);                                   // after edge 8 (PRIME)
    chk("prime_no_result", {15'd0, speed_valid}, 16'd0);
    step(7);                                   // after edge 15
    chk("pre_tick_idle", {15'd0, speed_valid}, 16'd0);
    step(1);                                   // after edge 16
    chk("hold_valid", {15'd0, speed_valid}, 16'd1);
    chk("hold_speed", speed, 16'd0);
    step(1);                                   // after edge 17
    chk("hold_pulse_end", {15'd0, speed_valid}, 16'd0);

    // Forward and reverse motion.
    count = 16'd150;
    step(7);                                   // after edge 24
    chk("fwd_speed", speed, 16'd50);
    chk("fwd_valid", {15'd0, speed_valid}, 16'd1);
    count = 16'd120;
    step(8);                                   // after edge 32
    chk("rev_speed", speed, 16'hFFE2);         // -30

    // Wrap handling.
    count = 16'd63990;
    step(8);                                   // after edge 40: 63870 -> -130
    chk("big_back", speed, 16'hFF7E);
    count = 16'd10;
    step(8);                                   // after edge 48
    chk("wrap_fwd", speed, 16'd20);
    count = 16'd63990;
    step(8);                                   // after edge 56
    chk("wrap_rev", speed, 16'hFFEC);          // -20
    step(1);                                   // after edge 57, consumed

    // New result in the same cycle as acceptance.
    speed_ready = 1'b0;
    count = 16'd0;                             // -63990 -> +10
    step(7);                                   // after edge 64
    chk("sim_first", speed, 16'd10);
    count = 16'd5;
    step(7);                                   // after edge 71
    chk("sim_stable", speed, 16'd10);
    chk("sim_hold_valid", {15'd0, speed_valid}, 16'd1);
    speed_ready = 1'b1;
    step(1);                                   // after edge 72
    chk("sim_new_speed", speed, 16'd5);
    chk("sim_valid_kept", {15'd0, speed_valid}, 16'd1);
    chk("sim_no_overrun", {15'd0, overrun}, 16'd0);
    step(1);                                   // after edge 73, consumed
    chk("sim_consumed", {15'd0, speed_valid}, 16'd0);

    // Overrun: two results without acceptance.
    speed_ready = 1'b0;
    count = 16'd10;
    step(7);                                   // after edge 80
    chk("ovr_first", speed, 16'd5);
    chk("ovr_none_yet", {15'd0, overrun}, 16'd0);
    count = 16'd17;
    step(8);                                   // after edge 88
    chk("ovr_speed", speed, 16'd7);
    chk("ovr_valid", {15'd0, speed_valid}, 16'd1);
    chk("ovr_flag", {15'd0, overrun}, 16'd1);
    speed_ready = 1'b1;
    step(1);                                   // after edge 89
    chk("ovr_accept", {15'd0, speed_valid}, 16'd0);
    chk("ovr_sticky", {15'd0, overrun}, 16'd1);

    // Reset mid-period with a pending result.
    speed_ready = 1'b0;
    count = 16'd20;
    step(7);                                   // after edge 96
    chk("pend_valid", {15'd0, speed_valid}, 16'd1);
    chk("pend_speed", speed, 16'd3);
    step(3);                                   // mid-period
    rst = 1'b1;
    #1;
    chk("arst_speed", speed, 16'd0);
    chk("arst_valid", {15'd0, speed_valid}, 16'd0);
    chk("arst_overrun", {15'd0, overrun}, 16'd0);
    step(3);
    rst = 1'b0;
    speed_ready = 1'b1;
    count = 16'd50;
    step(8);
    chk("rst_prime_again", {15'd0, speed_valid}, 16'd0);
    count = 16'd80;
    step(7);
    chk("rst_pre_tick", {15'd0, speed_valid}, 16'd0);
    step(1);
    chk("rst_first_speed", speed, 16'd30);
    chk("rst_first_valid", {15'd0, speed_valid}, 16'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encoder_speed.md
ENCODER_SPEED -- requirements
Module: encoder_speed

Interface
- REQ-001 Parameter ENCODER_MAX, default 64000: encoder count modulus; upstream count range is 0..ENCODER_MAX-1.
- REQ-002 Parameter SAMPLE_PERIOD, default 100000: clk cycles between samples (1 ms at 100 MHz); legal range 2..2^24-1.
- REQ-003 clk  input  1  single system clock; all logic on the rising edge.
- REQ-004 rst  input  1  reset, asynchronous and active-high.
- REQ-005 count  input  16  unsigned position count from the upstream Encoder, synchronous to clk.
- REQ-006 speed  output  16  signed two's-complement counts per sample period.
- REQ-007 speed_valid  output  1  speed holds an unconsumed result.
- REQ-008 speed_ready  input  1  consumer accepts speed when high together with speed_valid.
- REQ-009 overrun  output  1  sticky flag: at least one result was overwritten before acceptance.

Function
- REQ-010 The sample timer shall count 0..SAMPLE_PERIOD-1 and wrap; the sample tick shall be the cycle where the timer equals SAMPLE_PERIOD-1.
- REQ-011 The state machine shall have two states: PRIME (after reset) and RUN.
- REQ-012 In PRIME, the first tick shall latch count into prev and move to RUN without producing a result.
- REQ-013 In RUN, each tick shall compute d = count - prev in 17-bit signed arithmetic and latch count into prev.
- REQ-014 Wrap correction: if d > ENCODER_MAX/2 then d = d - ENCODER_MAX; if d < -(ENCODER_MAX/2) then d = d + ENCODER_MAX.
- REQ-015 The corrected d shall saturate to -32768..32767 before driving speed.
- REQ-016 speed and speed_valid shall update on the clock edge after the tick (latency 1 cycle, filter disabled).
- REQ-017 speed_valid shall stay high and speed stable until a cycle with speed_valid && speed_ready; speed_valid then clears on the next edge.
- REQ-018 A new result arriving while speed_valid is high and speed_ready is low shall overwrite speed, keep speed_valid high, and set overrun.
- REQ-019 A new result in the same cycle as an acceptance shall load the new value, keep speed_valid high, and leave overrun unchanged.
- REQ-020 overrun shall clear only on reset.
- REQ-021 speed_ready while speed_valid is low shall have no effect.

Reset
- REQ-022 While rst is high: timer=0, prev=0, state=PRIME, speed=0, speed_valid=0, overrun=0; filter history (if built) = 0.
- REQ-023 Reset asserted mid-period or with a pending result shall discard the result and the partial period; the first result after release follows the PRIME tick.

Configuration
- REQ-024 Macro ENCODER_SPEED_FILTER_EN: when defined, speed shall be the moving average of the last four corrected deltas (sum >>> 2, arithmetic shift, 18-bit sum), with latency 2 cycles after the tick; history slots not yet filled count as 0.
- REQ-025 Without ENCODER_SPEED_FILTER_EN, speed shall be the single corrected, saturated delta at 1-cycle latency, and no history registers shall exist.

Verification (SAMPLE_PERIOD=8, ENCODER_MAX=64000, filter off unless stated)
- REQ-026 Reset then count held at 100, speed_ready=1 -> no result at first tick; at every later tick speed=0, speed_valid pulses for 1 cycle.
- REQ-027 count steps 100 -> 150 between ticks -> speed=+50 one cycle after tick; 150 -> 120 -> speed=-30.
- REQ-028 Wrap: count 63990 -> 10 -> speed=+20; count 10 -> 63990 -> speed=-20.
- REQ-029 speed_ready=0 across two results (+5 then +7) -> speed=+7, speed_valid=1, overrun=1; ready=1 for one cycle -> speed_valid=0, overrun stays 1.
- REQ-030 rst pulsed 3 cycles mid-period with speed_valid=1 -> speed=0, speed_valid=0, overrun=0 immediately; next tick is PRIME (no result).
- REQ-031 ENCODER_SPEED_FILTER_EN defined, deltas +40,+40,+40,+40 -> speed 10, 20, 30, 40, each 2 cycles after its tick.
